lampfpu_sqrt_seq: RTL and testbench

LAMPFPU_SQRT_SEQ -- requirements
Module: lampfpu_sqrt_seq

---
 rtl/lampFPU_pkg.sv | 56 +++++
 rtl/lampfpu_sqrt_step.sv | 29 ++
 rtl/lampfpu_sqrt_seq.sv | 205 ++++++++++++++++++++
 tb/tb_lampfpu_sqrt_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
// Shared float constants, sqrt FSM state type and special-operand resolution for the sqrt unit.
package lampFPU_pkg;

  localparam int unsigned LAMP_FLOAT_F_DW   = 7;
  localparam int unsigned LAMP_FLOAT_E_DW   = 8;
  localparam int unsigned LAMP_FLOAT_E_BIAS = 127;
  localparam int unsigned LAMP_FLOAT_EF_DW  = LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  localparam logic [LAMP_FLOAT_EF_DW-1:0] ZERO_E_F = '0;
  localparam logic [LAMP_FLOAT_EF_DW-1:0] INF_E_F  =
    {{LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};
  localparam logic [LAMP_FLOAT_EF_DW-1:0] QNAN_E_F =
    {{LAMP_FLOAT_E_DW{1'b1}}, 1'b1, {(LAMP_FLOAT_F_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } sqrt_state_t;

  typedef struct packed {
    logic                        is_special;
    logic                        s;
    logic [LAMP_FLOAT_EF_DW-1:0] e_f;
    logic                        invalid;
  } sqrt_special_t;

  // NaN wins, then signed zero, then any other negative operand, then +Inf.
  function automatic sqrt_special_t FUNC_calcInfNanZeroResSqrt(
    input logic s,
    input logic is_z,
    input logic is_inf,
    input logic is_snan,
    input logic is_qnan
  );
    sqrt_special_t r;
    r            = '0;
    r.is_special = 1'b1;
    if (is_snan || is_qnan) begin
      r.e_f     = QNAN_E_F;
      r.invalid = is_snan;
    end else if (is_z) begin
      r.s   = s;
      r.e_f = ZERO_E_F;
    end else if (s) begin
      r.e_f     = QNAN_E_F;
      r.invalid = 1'b1;
    end else if (is_inf) begin
      r.e_f = INF_E_F;
    end else begin
      r.is_special = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/lampfpu_sqrt_step.sv
// One radix-2 restoring square-root iteration: consumes two radicand bits, emits one root bit.
module lampfpu_sqrt_step #(
  parameter int unsigned N = 10
) (
  input  logic [N+1:0] rem_in,
  input  logic [N-1:0] root_in,
  input  logic [1:0]   pair,
  output logic [N+1:0] rem_out,
  output logic [N-1:0] root_out
);

  localparam int unsigned RW = N + 2;

  logic [RW+1:0] shifted;
  logic [RW+1:0] trial;
  logic [RW+1:0] diff;
  logic          take;

  // Trial subtrahend is 4*root+1; accepting it sets the new root bit.
  always_comb begin
    shifted  = {rem_in, pair};
    trial    = (RW+2)'({root_in, 2'b01});
    diff     = shifted - trial;
    take     = (shifted >= trial);
    rem_out  = take ? RW'(diff) : RW'(shifted);
    root_out = N'({root_in, take});
  end

endmodule

// File: rtl/lampfpu_sqrt_seq.sv
// Sequential bit-per-cycle square root with fixed latency, flush and special-operand handling.
module lampfpu_sqrt_seq
  import lampFPU_pkg::*;
#(
  parameter int unsigned F_DW   = LAMP_FLOAT_F_DW,
  parameter int unsigned E_DW   = LAMP_FLOAT_E_DW,
  parameter int unsigned E_BIAS = LAMP_FLOAT_E_BIAS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       doSqrt_i,
  input  logic                       flush_i,
  input  logic                       s_i,
  input  logic [F_DW:0]              extF_i,
  input  logic [E_DW:0]              extE_i,
  input  logic [$clog2(F_DW+1)-1:0]  nlz_i,
  input  logic                       isZ_i,
  input  logic                       isInf_i,
  input  logic                       isSNAN_i,
  input  logic                       isQNAN_i,
  output logic                       s_res_o,
  output logic [E_DW-1:0]            e_res_o,
  output logic [F_DW+4:0]            f_res_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       isToRound_o,
  output logic                       isInvalid_o,
  output logic                       isOverflow_o,
  output logic                       isUnderflow_o
);

  localparam int unsigned N    = F_DW + 3;
  localparam int unsigned RADW = 2 * N;
  localparam int unsigned REMW = N + 2;
  localparam int unsigned CW   = $clog2(N);
  localparam int unsigned UW   = E_DW + 2;

  sqrt_state_t       state_q, state_nxt;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic [RADW-1:0]   rad_q, rad_nxt;
  logic [REMW-1:0]   rem_q, rem_nxt;
  logic [N-1:0]      root_q, root_nxt;
  logic [E_DW-1:0]   e_q, e_nxt;
  logic              op_s_q, op_s_nxt;
  logic              is_z_q, is_z_nxt;
  logic              is_inf_q, is_inf_nxt;
  logic              is_snan_q, is_snan_nxt;
  logic              is_qnan_q, is_qnan_nxt;
  logic              s_res_nxt, valid_nxt, busy_nxt, round_nxt, invalid_nxt;
  logic [E_DW-1:0]   e_res_nxt;
  logic [F_DW+4:0]   f_res_nxt;

  logic [F_DW:0]          norm_f;
  logic signed [UW-1:0]   u;
  logic signed [UW-1:0]   u_half;
  logic [E_DW-1:0]        e_acc;
  logic [RADW-1:0]        rad_init;
  logic [REMW-1:0]        step_rem;
  logic [N-1:0]           step_root;
  sqrt_special_t          sp;

  // Operand normalisation: odd exponents fold one factor of two into the radicand.
  always_comb begin
    norm_f   = (F_DW+1)'(extF_i << nlz_i);
    u        = UW'(extE_i) - UW'(nlz_i) - UW'(E_BIAS);
    u_half   = u >>> 1;
    e_acc    = E_DW'(u_half + UW'(E_BIAS));
    rad_init = u[0] ? (RADW'(norm_f) << (F_DW + 5)) : (RADW'(norm_f) << (F_DW + 4));
  end

  lampfpu_sqrt_step #(.N(N)) u_step (
    .rem_in   (rem_q),
    .root_in  (root_q),
    .pair     (rad_q[RADW-1 -: 2]),
    .rem_out  (step_rem),
    .root_out (step_root)
  );

  assign sp = FUNC_calcInfNanZeroResSqrt(op_s_q, is_z_q, is_inf_q, is_snan_q, is_qnan_q);

  assign isOverflow_o  = 1'b0;
  assign isUnderflow_o = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      e_q         <= '0;
      op_s_q      <= 1'b0;
      is_z_q      <= 1'b0;
      is_inf_q    <= 1'b0;
      is_snan_q   <= 1'b0;
      is_qnan_q   <= 1'b0;
      s_res_o     <= 1'b0;
      e_res_o     <= '0;
      f_res_o     <= '0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
      isToRound_o <= 1'b0;
      isInvalid_o <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      rad_q       <= rad_nxt;
      rem_q       <= rem_nxt;
      root_q      <= root_nxt;
      e_q         <= e_nxt;
      op_s_q      <= op_s_nxt;
      is_z_q      <= is_z_nxt;
      is_inf_q    <= is_inf_nxt;
      is_snan_q   <= is_snan_nxt;
      is_qnan_q   <= is_qnan_nxt;
      s_res_o     <= s_res_nxt;
      e_res_o     <= e_res_nxt;
      f_res_o     <= f_res_nxt;
      valid_o     <= valid_nxt;
      busy_o      <= busy_nxt;
      isToRound_o <= round_nxt;
      isInvalid_o <= invalid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    rad_nxt     = rad_q;
    rem_nxt     = rem_q;
    root_nxt    = root_q;
    e_nxt       = e_q;
    op_s_nxt    = op_s_q;
    is_z_nxt    = is_z_q;
    is_inf_nxt  = is_inf_q;
    is_snan_nxt = is_snan_q;
    is_qnan_nxt = is_qnan_q;
    s_res_nxt   = s_res_o;
    e_res_nxt   = e_res_o;
    f_res_nxt   = f_res_o;
    round_nxt   = isToRound_o;
    invalid_nxt = isInvalid_o;
    valid_nxt   = 1'b0;
    busy_nxt    = busy_o;

    case (state_q)
      IDLE: begin
        if (doSqrt_i && !flush_i) begin
          state_nxt   = ITER;
          cnt_nxt     = '0;
          rad_nxt     = rad_init;
          rem_nxt     = '0;
          root_nxt    = '0;
          e_nxt       = e_acc;
          op_s_nxt    = s_i;
          is_z_nxt    = isZ_i;
          is_inf_nxt  = isInf_i;
          is_snan_nxt = isSNAN_i;
          is_qnan_nxt = isQNAN_i;
          busy_nxt    = 1'b1;
        end
      end
      ITER: begin
        if (flush_i) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          rem_nxt  = step_rem;
          root_nxt = step_root;
          rad_nxt  = rad_q << 2;
          cnt_nxt  = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_nxt = FIN;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        if (!flush_i) begin
          valid_nxt = 1'b1;
          if (sp.is_special) begin
            s_res_nxt   = sp.s;
            e_res_nxt   = E_DW'(sp.e_f[LAMP_FLOAT_EF_DW-1:LAMP_FLOAT_F_DW]);
            f_res_nxt   = {1'b0, |sp.e_f[LAMP_FLOAT_EF_DW-1:LAMP_FLOAT_F_DW],
                           F_DW'(sp.e_f[LAMP_FLOAT_F_DW-1:0]), 3'b000};
            round_nxt   = 1'b0;
            invalid_nxt = sp.invalid;
          end else begin
            s_res_nxt   = op_s_q;
            e_res_nxt   = e_q;
            f_res_nxt   = {1'b0, root_q, |rem_q};
            round_nxt   = 1'b1;
            invalid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lampfpu_sqrt_seq.sv
// Self-checking bench for lampfpu_sqrt_seq against an arithmetic square-root reference model.
module tb_lampfpu_sqrt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        do_sqrt, flush;
  logic        op_s;
  logic [7:0]  op_f;
  logic [8:0]  op_e;
  logic [2:0]  op_nlz;
  logic        op_z, op_inf, op_snan, op_qnan;
  logic        s_res;
  logic [7:0]  e_res;
  logic [11:0] f_res;
  logic        valid, busy, to_round, invalid, overflow, underflow;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int busy_bad;

  logic        exp_s;
  logic [7:0]  exp_e;
  logic [11:0] exp_f;
  logic        exp_round, exp_inv;

  always #5 clk = ~clk;

  lampfpu_sqrt_seq dut (
    .clk(clk), .rst(rst), .doSqrt_i(do_sqrt), .flush_i(flush),
    .s_i(op_s), .extF_i(op_f), .extE_i(op_e), .nlz_i(op_nlz),
    .isZ_i(op_z), .isInf_i(op_inf), .isSNAN_i(op_snan), .isQNAN_i(op_qnan),
    .s_res_o(s_res), .e_res_o(e_res), .f_res_o(f_res), .valid_o(valid), .busy_o(busy),
    .isToRound_o(to_round), .isInvalid_o(invalid),
    .isOverflow_o(overflow), .isUnderflow_o(underflow)
  );

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) valid_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Reference: square root of the operand value, computed with integer arithmetic.
  task automatic model();
    longint x, q;
    int m, u, half;
    bit odd;
    exp_s = 1'b0; exp_e = 8'd0; exp_f = 12'd0; exp_round = 1'b0; exp_inv = 1'b0;
    if (op_snan || op_qnan) begin
      exp_e = 8'd255; exp_f = 12'h600; exp_inv = op_snan;
    end else if (op_z) begin
      exp_s = op_s;
    end else if (op_s) begin
      exp_e = 8'd255; exp_f = 12'h600; exp_inv = 1'b1;
    end else if (op_inf) begin
      exp_e = 8'd255; exp_f = 12'h400;
    end else begin
      m    = (int'(op_f) << op_nlz) & 255;
      u    = int'(op_e) - int'(op_nlz) - 127;
      odd  = (u % 2) != 0;
      half = (u >= 0) ? u / 2 : -((1 - u) / 2);
      x    = longint'(m) << (odd ? 12 : 11);
      q    = 0;
      while ((q + 1) * (q + 1) <= x) q++;
      exp_e     = 8'(half + 127);
      exp_f     = {1'b0, 10'(q), (q * q != x)};
      exp_round = 1'b1;
    end
  endtask

  task automatic set_normal();
    op_s = 1'b0; op_e = 9'($urandom_range(1, 254)); op_f = {1'b1, 7'($urandom)};
    op_nlz = 3'd0; op_z = 1'b0; op_inf = 1'b0; op_snan = 1'b0; op_qnan = 1'b0;
  endtask

  task automatic set_random_op();
    int k, n;
    k = $urandom_range(0, 9);
    set_normal();
    case (k)
      5: begin
        op_e = 9'd1; op_f = 8'($urandom_range(1, 127)); n = 0;
        for (int b = 7; b >= 0; b--) begin
          if (op_f[b]) break;
          n++;
        end
        op_nlz = 3'(n);
      end
      6: begin op_z = 1'b1; op_e = 9'd0; op_f = 8'd0; op_s = 1'($urandom); end
      7: begin op_inf = 1'b1; op_e = 9'd255; op_f = 8'h80; op_s = 1'($urandom); end
      8: begin
        op_e = 9'd255; op_f = 8'h80 | 8'($urandom_range(1, 127));
        op_snan = 1'($urandom); op_qnan = ~op_snan;
      end
      9: op_s = 1'b1;
      default: ;
    endcase
  endtask

  // Issue the current operand, scramble inputs after acceptance, return edges until valid.
  task automatic issue(output int lat);
    @(negedge clk); do_sqrt = 1'b1;
    @(posedge clk);
    @(negedge clk); do_sqrt = 1'b0;
    op_s = 1'($urandom); op_f = 8'($urandom); op_e = 9'($urandom); op_nlz = 3'($urandom);
    op_z = 1'($urandom); op_inf = 1'($urandom); op_snan = 1'($urandom); op_qnan = 1'($urandom);
    lat = -1; busy_bad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin lat = k; break; end
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; do_sqrt = 1'b0; flush = 1'b0; set_normal();
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({s_res, e_res, f_res, valid, busy, to_round, invalid, overflow, underflow} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got s=%b e=%h f=%h v=%b b=%b r=%b i=%b required all zero",
               s_res, e_res, f_res, valid, busy, to_round, invalid);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b required 0 0", busy, valid);
    end
  endtask

  task automatic test_directed();
    int lat;
    logic [22:0] want;
    for (int i = 0; i < 4; i++) begin
      set_normal();
      case (i)
        0: begin op_e = 9'd129; op_f = 8'h80; want = {1'b0, 8'd128, 12'h400, 1'b1, 1'b0}; end
        1: begin op_e = 9'd128; op_f = 8'h80; want = {1'b0, 8'd127, 12'h5A9, 1'b1, 1'b0}; end
        2: begin op_s = 1'b1; op_e = 9'd127; op_f = 8'h80; want = {1'b0, 8'd255, 12'h600, 1'b0, 1'b1}; end
        default: begin op_s = 1'b1; op_z = 1'b1; op_e = 9'd0; op_f = 8'h00; want = {1'b1, 8'd0, 12'h000, 1'b0, 1'b0}; end
      endcase
      issue(lat);
      checks++;
      if (lat != 11 || busy_bad != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got lat=%0d busy_bad=%0d busy=%b required 11 0 0",
                 i, lat, busy_bad, busy);
      end
      checks++;
      if ({s_res, e_res, f_res, to_round, invalid} !== want) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h required %h", i,
                 {s_res, e_res, f_res, to_round, invalid}, want);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if (valid !== 1'b0 || {s_res, e_res, f_res, to_round, invalid} !== want) begin
        errors++;
        $display("FAIL directed_hold[%0d]: got v=%b %h required v=0 %h", i, valid,
                 {s_res, e_res, f_res, to_round, invalid}, want);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 150; i++) begin
      set_random_op();
      model();
      issue(lat);
      checks++;
      if (lat != 11 || busy_bad != 0) begin
        errors++;
        $display("FAIL random_latency[%0d]: got lat=%0d busy_bad=%0d required 11 0", i, lat, busy_bad);
      end
      checks++;
      if ({s_res, e_res, f_res, to_round, invalid, overflow, underflow} !==
          {exp_s, exp_e, exp_f, exp_round, exp_inv, 2'b00}) begin
        errors++;
        $display("FAIL random_result[%0d]: got s=%b e=%h f=%h r=%b i=%b ov=%b un=%b required s=%b e=%h f=%h r=%b i=%b ov=0 un=0",
                 i, s_res, e_res, f_res, to_round, invalid, overflow, underflow,
                 exp_s, exp_e, exp_f, exp_round, exp_inv);
      end
    end
  endtask

  task automatic test_back_to_back();
    int v0, lat;
    logic [22:0] want_a;
    v0 = valid_cnt;
    set_normal(); model();
    want_a = {exp_s, exp_e, exp_f, exp_round, exp_inv};
    @(negedge clk); do_sqrt = 1'b1;
    @(posedge clk);
    @(negedge clk); do_sqrt = 1'b0;
    repeat (2) @(negedge clk);
    set_normal(); do_sqrt = 1'b1;
    @(negedge clk); do_sqrt = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat < 0 || {s_res, e_res, f_res, to_round, invalid} !== want_a) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d %h required %h", lat,
               {s_res, e_res, f_res, to_round, invalid}, want_a);
    end
    set_random_op(); model();
    issue(lat);
    checks++;
    if (lat != 11 || {s_res, e_res, f_res, to_round, invalid} !== {exp_s, exp_e, exp_f, exp_round, exp_inv}) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d %h required lat=11 %h", lat,
               {s_res, e_res, f_res, to_round, invalid}, {exp_s, exp_e, exp_f, exp_round, exp_inv});
    end
    repeat (15) @(posedge clk); #1;
    checks++;
    if (valid_cnt != v0 + 2) begin
      errors++;
      $display("FAIL b2b_pulse_count: got %0d required 2", valid_cnt - v0);
    end
  endtask

  task automatic test_flush();
    int v0, lat;
    v0 = valid_cnt;
    set_normal();
    @(negedge clk); do_sqrt = 1'b1;
    @(posedge clk);
    @(negedge clk); do_sqrt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_iter_busy: got busy=%b required 0", busy);
    end
    @(negedge clk); flush = 1'b0;
    set_random_op(); model();
    do_sqrt = 1'b1;
    @(posedge clk);
    @(negedge clk); do_sqrt = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat != 11 || valid_cnt != v0 + 1 ||
        {s_res, e_res, f_res, to_round, invalid} !== {exp_s, exp_e, exp_f, exp_round, exp_inv}) begin
      errors++;
      $display("FAIL flush_then_new: got lat=%0d pulses=%0d %h required 11 1 %h", lat, valid_cnt - v0,
               {s_res, e_res, f_res, to_round, invalid}, {exp_s, exp_e, exp_f, exp_round, exp_inv});
    end
    @(negedge clk); do_sqrt = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_priority: got busy=%b required 0", busy);
    end
    @(negedge clk); do_sqrt = 1'b0; flush = 1'b0;
    set_normal();
    v0 = valid_cnt;
    @(negedge clk); do_sqrt = 1'b1;
    @(posedge clk);
    @(negedge clk); do_sqrt = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_fin: got valid=%b busy=%b required 0 0", valid, busy);
    end
    @(negedge clk); flush = 1'b0;
    repeat (15) @(posedge clk); #1;
    checks++;
    if (valid_cnt != v0) begin
      errors++;
      $display("FAIL flush_no_valid: got %0d pulses required 0", valid_cnt - v0);
    end
  endtask

  task automatic test_async_reset();
    int v0, lat;
    set_normal();
    @(negedge clk); do_sqrt = 1'b1;
    @(posedge clk);
    @(negedge clk); do_sqrt = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({s_res, e_res, f_res, valid, busy, to_round, invalid} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset_clear: got s=%b e=%h f=%h v=%b b=%b r=%b i=%b required all zero",
               s_res, e_res, f_res, valid, busy, to_round, invalid);
    end
    @(negedge clk); rst = 1'b0;
    v0 = valid_cnt;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (valid_cnt != v0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_discard: got pulses=%0d busy=%b required 0 0", valid_cnt - v0, busy);
    end
    set_normal(); model();
    issue(lat);
    checks++;
    if (lat != 11 || {s_res, e_res, f_res, to_round, invalid} !== {exp_s, exp_e, exp_f, exp_round, exp_inv}) begin
      errors++;
      $display("FAIL async_reset_recover: got lat=%0d %h required 11 %h", lat,
               {s_res, e_res, f_res, to_round, invalid}, {exp_s, exp_e, exp_f, exp_round, exp_inv});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
